// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: reads the resized grayscale image back out of the
// destination RAM and streams it with VGA timing, centred on a black border.
// Image dimensions are re-sampled only on the first vblank line so a resize
// never tears a frame. Output path is two pixel ticks deep:
// counters -> (address, delayed syncs) -> (pixel, syncs).
module framebuffer_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        img_width,
  input  logic [9:0]        img_height,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [7:0]        pix,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]        h_cnt, v_cnt;
  logic [9:0]        shadow_w, shadow_h, x_off, y_off;
  logic [ADDR_W-1:0] run_addr;
  logic              hs_d1, vs_d1, bl_d1;

  logic       latch, in_img, visible, hs_act, vs_act;
  logic [9:0] w_clamp, h_clamp;

  // Decode the current counter position.
  always_comb begin
    w_clamp = (img_width  > H_ACT) ? H_ACT : img_width;
    h_clamp = (img_height > V_ACT) ? V_ACT : img_height;
    latch   = (h_cnt == 10'd0) && (v_cnt == V_ACT);
    // Zero width/height makes the upper bound equal the lower: never true.
    in_img  = (h_cnt >= x_off) && (h_cnt < x_off + shadow_w) &&
              (v_cnt >= y_off) && (v_cnt < y_off + shadow_h);
    visible = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_act  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_act  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // Raster counters; frame_start pulses only on the tick evaluating (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Shadow dimensions and running address; latch wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w <= '0;
      shadow_h <= '0;
      x_off    <= '0;
      y_off    <= '0;
      run_addr <= '0;
    end else if (pix_en) begin
      if (latch) begin
        shadow_w <= w_clamp;
        shadow_h <= h_clamp;
        x_off    <= (H_ACT - w_clamp) >> 1;
        y_off    <= (V_ACT - h_clamp) >> 1;
        run_addr <= '0;
      end else if (in_img && run_addr != '1) begin
        run_addr <= run_addr + ADDR_W'(1);
      end
    end
  end

  // Stage 1: issue the RAM read and delay the timing signals to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
      hs_d1   <= 1'b1;
      vs_d1   <= 1'b1;
      bl_d1   <= 1'b0;
    end else if (pix_en) begin
      rd_en <= in_img;
      if (in_img) rd_addr <= run_addr;
      hs_d1 <= ~hs_act;
      vs_d1 <= ~vs_act;
      bl_d1 <= visible;
    end
  end

  // Stage 2: capture RAM data for in-image pixels, black elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix     <= 8'h00;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else if (pix_en) begin
      pix     <= rd_en ? rd_data : 8'h00;
      hsync   <= hs_d1;
      vsync   <= vs_d1;
      blank_n <= bl_d1;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a scaled-down raster (32x24 visible,
// 40x29 total) so whole frames are cheap. Dimensions in the directed cases
// are the full-size cases divided by 20.
module tb_framebuffer_scanout;

  localparam int HT = 40;
  localparam int F  = 40 * 29;

  logic        clk, rst_n, pix_en;
  logic [9:0]  img_width, img_height;
  logic [7:0]  rd_data;
  logic [15:0] rd_addr;
  logic        rd_en, hsync, vsync, blank_n, frame_start;
  logic [7:0]  pix;

  framebuffer_scanout #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(24), .V_FP(1), .V_SYNC(2), .V_BP(2), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .img_width(img_width), .img_height(img_height), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_en(rd_en), .pix(pix), .hsync(hsync),
    .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address a holds a[7:0], one register of read latency.
  always @(posedge clk) rd_data <= rd_addr[7:0];

  int checks = 0, failures = 0;
  int tk;
  int fs_cnt, hs_cnt, vs_cnt, bl_cnt, rd_cnt, pix_nz, pix_err, seq_err;
  int first_pos, last_pos, a9_pos;
  logic [15:0] first_addr, last_addr, exp_next, prev_addr;
  logic        prev_en;

  task automatic clr_stats();
    fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; rd_cnt = 0;
    pix_nz = 0; pix_err = 0; seq_err = 0;
    first_pos = -1; last_pos = -1; a9_pos = -1;
    first_addr = '0; last_addr = '0;
  endtask

  // One pixel tick (pix_en high for one clk out of two), then gather stats.
  task automatic tick();
    int pos;
    logic [7:0] exp_pix;
    @(negedge clk) pix_en = 1'b1;
    @(negedge clk) pix_en = 1'b0;
    pos = tk % F;
    tk++;
    if (frame_start) fs_cnt++;
    if (!hsync) hs_cnt++;
    if (!vsync) vs_cnt++;
    if (blank_n) bl_cnt++;
    if (pix != 8'h00) pix_nz++;
    exp_pix = prev_en ? prev_addr[7:0] : 8'h00;
    if (pix !== exp_pix) pix_err++;
    if (rd_en) begin
      rd_cnt++;
      if (first_pos < 0) begin first_pos = pos; first_addr = rd_addr; end
      last_pos = pos; last_addr = rd_addr;
      if (rd_addr == 16'd9 && a9_pos < 0) a9_pos = pos;
      if (rd_addr != 16'd0 && rd_addr != exp_next) seq_err++;
      exp_next = rd_addr + 16'd1;
    end
    prev_en = rd_en; prev_addr = rd_addr;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    pix_en = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tk = 0; prev_en = 1'b0; prev_addr = '0; exp_next = '0;
  endtask

  task automatic test_reset();
    img_width = 10'd8; img_height = 10'd6;
    do_reset();
    run_ticks(F + 10 * HT + 15);
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL pre_reset_rd_en got=%b exp=1", rd_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, rd_en, pix, hsync, vsync, blank_n, frame_start} !== {16'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got addr=%0d en=%b pix=%0d hs=%b vs=%b bl=%b fs=%b exp 0/0/0/1/1/0/0",
               rd_addr, rd_en, pix, hsync, vsync, blank_n, frame_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tk = 0; prev_en = 1'b0; prev_addr = '0; exp_next = '0;
    tick();
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL first_tick_frame_start got=%b exp=1", frame_start); end
    tick();
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL second_tick_frame_start got=%b exp=0", frame_start); end
    checks++; if (blank_n !== 1'b1) begin failures++; $display("FAIL pos0_blank_n got=%b exp=1", blank_n); end
    clr_stats();
    run_ticks(F - 2);
    checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL post_reset_black rd_cnt got=%0d exp=0", rd_cnt); end
    checks++; if (pix_nz !== 0) begin failures++; $display("FAIL post_reset_black pix_nz got=%0d exp=0", pix_nz); end
  endtask

  task automatic test_blank_frames();
    img_width = 10'd0; img_height = 10'd0;
    do_reset();
    clr_stats();
    run_ticks(2 * F);
    checks++; if (hs_cnt !== 232) begin failures++; $display("FAIL hsync_low got=%0d exp=232", hs_cnt); end
    checks++; if (vs_cnt !== 160) begin failures++; $display("FAIL vsync_low got=%0d exp=160", vs_cnt); end
    checks++; if (bl_cnt !== 1536) begin failures++; $display("FAIL blank_n_high got=%0d exp=1536", bl_cnt); end
    checks++; if (fs_cnt !== 2) begin failures++; $display("FAIL frame_start_cnt got=%0d exp=2", fs_cnt); end
    checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL zero_img_rd got=%0d exp=0", rd_cnt); end
    checks++; if (pix_nz !== 0) begin failures++; $display("FAIL zero_img_pix got=%0d exp=0", pix_nz); end
  endtask

  task automatic test_small_image();
    img_width = 10'd8; img_height = 10'd6;
    do_reset();
    run_ticks(F);
    clr_stats();
    run_ticks(F);
    checks++; if (first_pos !== 9 * HT + 12) begin failures++; $display("FAIL small_first_pos got=%0d exp=%0d", first_pos, 9 * HT + 12); end
    checks++; if (first_addr !== 16'd0) begin failures++; $display("FAIL small_first_addr got=%0d exp=0", first_addr); end
    checks++; if (last_addr !== 16'd47) begin failures++; $display("FAIL small_last_addr got=%0d exp=47", last_addr); end
    checks++; if (last_pos !== 14 * HT + 19) begin failures++; $display("FAIL small_last_pos got=%0d exp=%0d", last_pos, 14 * HT + 19); end
    checks++; if (rd_cnt !== 48) begin failures++; $display("FAIL small_rd_cnt got=%0d exp=48", rd_cnt); end
    checks++; if (pix_nz !== 47) begin failures++; $display("FAIL small_pix_nz got=%0d exp=47", pix_nz); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL small_pix_data got=%0d errors exp=0", pix_err); end
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL small_addr_seq got=%0d errors exp=0", seq_err); end
  endtask

  task automatic test_resize_mid_frame();
    clr_stats();
    run_ticks(10 * HT);
    img_width = 10'd16; img_height = 10'd12;
    run_ticks(F - 10 * HT);
    checks++; if (rd_cnt !== 48) begin failures++; $display("FAIL torn_frame rd_cnt got=%0d exp=48", rd_cnt); end
    checks++; if (last_addr !== 16'd47) begin failures++; $display("FAIL torn_frame last_addr got=%0d exp=47", last_addr); end
    clr_stats();
    run_ticks(F);
    checks++; if (first_pos !== 6 * HT + 8) begin failures++; $display("FAIL resized_first_pos got=%0d exp=%0d", first_pos, 6 * HT + 8); end
    checks++; if (rd_cnt !== 192) begin failures++; $display("FAIL resized_rd_cnt got=%0d exp=192", rd_cnt); end
    checks++; if (last_pos !== 17 * HT + 23) begin failures++; $display("FAIL resized_last_pos got=%0d exp=%0d", last_pos, 17 * HT + 23); end
    checks++; if (last_addr !== 16'd191) begin failures++; $display("FAIL resized_last_addr got=%0d exp=191", last_addr); end
  endtask

  task automatic test_clamp();
    img_width = 10'd40; img_height = 10'd30;
    run_ticks(F);
    clr_stats();
    run_ticks(F);
    checks++; if (first_pos !== 0) begin failures++; $display("FAIL clamp_first_pos got=%0d exp=0", first_pos); end
    checks++; if (rd_cnt !== 768) begin failures++; $display("FAIL clamp_rd_cnt got=%0d exp=768", rd_cnt); end
    checks++; if (last_addr !== 16'd767) begin failures++; $display("FAIL clamp_last_addr got=%0d exp=767", last_addr); end
    checks++; if (last_pos !== 23 * HT + 31) begin failures++; $display("FAIL clamp_last_pos got=%0d exp=%0d", last_pos, 23 * HT + 31); end
    checks++; if (pix_nz !== 765) begin failures++; $display("FAIL clamp_pix_nz got=%0d exp=765", pix_nz); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL clamp_pix_data got=%0d errors exp=0", pix_err); end
  endtask

  task automatic test_odd_and_freeze();
    logic [15:0] s_addr;
    logic [7:0]  s_pix;
    logic [3:0]  s_ctl;
    img_width = 10'd9; img_height = 10'd7;
    run_ticks(F);
    clr_stats();
    run_ticks(8 * HT + 15);
    checks++; if (rd_addr !== 16'd3 || rd_en !== 1'b1) begin failures++; $display("FAIL pre_freeze got addr=%0d en=%b exp addr=3 en=1", rd_addr, rd_en); end
    s_addr = rd_addr; s_pix = pix; s_ctl = {rd_en, hsync, vsync, blank_n};
    repeat (5) @(negedge clk);
    checks++;
    if (rd_addr !== s_addr || pix !== s_pix || {rd_en, hsync, vsync, blank_n} !== s_ctl || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL freeze got addr=%0d pix=%0d ctl=%b fs=%b exp addr=%0d pix=%0d ctl=%b fs=0",
               rd_addr, pix, {rd_en, hsync, vsync, blank_n}, frame_start, s_addr, s_pix, s_ctl);
    end
    run_ticks(F - (8 * HT + 15));
    checks++; if (first_pos !== 8 * HT + 11) begin failures++; $display("FAIL odd_first_pos got=%0d exp=%0d", first_pos, 8 * HT + 11); end
    checks++; if (a9_pos !== 9 * HT + 11) begin failures++; $display("FAIL odd_addr9_pos got=%0d exp=%0d", a9_pos, 9 * HT + 11); end
    checks++; if (rd_cnt !== 63) begin failures++; $display("FAIL odd_rd_cnt got=%0d exp=63", rd_cnt); end
    checks++; if (last_addr !== 16'd62) begin failures++; $display("FAIL odd_last_addr got=%0d exp=62", last_addr); end
    checks++; if (last_pos !== 14 * HT + 19) begin failures++; $display("FAIL odd_last_pos got=%0d exp=%0d", last_pos, 14 * HT + 19); end
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL odd_addr_seq got=%0d errors exp=0", seq_err); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL odd_pix_data got=%0d errors exp=0", pix_err); end
  endtask

  initial begin
    rst_n = 1'b1; pix_en = 1'b0; img_width = '0; img_height = '0;
    tk = 0; prev_en = 1'b0; prev_addr = '0; exp_next = '0;
    clr_stats();
    test_reset();
    test_blank_frames();
    test_small_image();
    test_resize_mid_frame();
    test_clamp();
    test_odd_and_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Reader side of the destination image RAM that the image ALU fills via addr_out/data_out/wren.
- Fetches the resized 8-bit grayscale image from that RAM and streams it as 640x480 VGA timing.
- The image is centred on screen with a black border around it.
- Image dimensions are taken from the active algorithm's NEW_WIDTH/NEW_HEIGHT and committed only during vertical blanking, so a frame is never torn by a resize.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync pulse width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
ADDR_W, 16, RAM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel tick enable; ticks spaced >=2 clk apart, or held high for a >=2-clk divided pixel clock
img_width  in  10  width of the stored image
img_height  in  10  height of the stored image
rd_data  in  8  RAM read data, valid 2 clk edges after rd_addr changes
rd_addr  out  ADDR_W  RAM read address
rd_en  out  1  read strobe; high while rd_addr is an in-image address
pix  out  8  grayscale pixel to the DAC
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
blank_n  out  1  high during the visible region
frame_start  out  1  one-clk pulse at the counter tick where h=0, v=0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low:
  - counters h_cnt = v_cnt = 0;
  - shadow width/height = 0, x_off = y_off = 0, running address = 0;
  - outputs rd_addr = 0, rd_en = 0, pix = 0, hsync = 1, vsync = 1, blank_n = 0, frame_start = 0.
  - Reset mid-frame abandons the frame; after release, scan restarts at (0,0) with a black screen until the next dimension latch.
- Advance: all state advances only on clk edges where pix_en = 1. With pix_en = 0, everything holds, except frame_start, which clears.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800), then wraps to 0 and increments v_cnt.
  - v_cnt runs 0..V_TOTAL-1 (525), then wraps to 0.
- Visible region: h < H_ACTIVE and v < V_ACTIVE.
- Sync windows:
  - hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752).
  - vsync is low for v in [490, 492).
- Dimension latch: at the tick where h = 0 and v = V_ACTIVE (first vblank line):
  - shadow_w = min(img_width, H_ACTIVE); shadow_h = min(img_height, V_ACTIVE);
  - x_off = (H_ACTIVE - shadow_w) >> 1; y_off = (V_ACTIVE - shadow_h) >> 1 (floor);
  - running address resets to 0.
  - Changes to img_width/img_height at any other time have no effect.
- In-image test: x_off <= h < x_off+shadow_w and y_off <= v < y_off+shadow_h. If shadow_w = 0 or shadow_h = 0, the test is never true.
- Address generation (stage 1, registered): on each in-image tick, rd_addr <= running address, rd_en <= 1, then running address increments. The address therefore equals (v-y_off)*shadow_w + (h-x_off); no multiplier is used. Not-in-image ticks set rd_en <= 0 and hold rd_addr.
- Output (stage 2): pix <= (in-image delayed one tick) ? rd_data : 8'h00.
- Alignment: hsync, vsync and blank_n pass through the same 2-tick delay, so pix, syncs and blank_n align and lag the counters by exactly 2 ticks. Outside the visible region pix = 0.
- Address width: the running address is ADDR_W bits and saturates at 2^ADDR_W-1 (no wrap). Images whose area exceeds the address space are caller error.
- Simultaneous events: the latch tick coincides with the frame-end line start; latch takes precedence over running-address increment (no in-image pixel can occur on line V_ACTIVE anyway).

Test Plan:
1. rst_n low for 3 clk mid-line (h=300, v=100) -> outputs at reset values immediately (async); after release the first tick gives h=1, v=0 and pix stays 0 until a dimension latch.
2. img 0x0, pix_en every 2nd clk, 2 frames -> hsync low 96 of every 800 ticks; vsync low exactly lines 490-491; rd_en never 1; pix always 0; frame_start once per 420000 ticks.
3. img 160x120, RAM addr a holds a[7:0], run to the second frame:
   - first rd_addr 0 at counter (240,180); pix = 8'h00 at output tick (242,180); last rd_addr 19199 at (399,299);
   - exactly 19200 rd_en ticks per frame; border pixels all 0.
4. Change img to 320x240 at v=200 of a 160x120 frame -> remainder of that frame is still 160x120; next frame x_off = 160, y_off = 120; first rd_addr 0 at (160,120).
5. img 800x600 -> clamped to 640x480, offsets 0; rd_addr 0 at (0,0); 307200 reads per frame.
6. img 161x121 -> x_off = 239, y_off = 179; rd_addr 161 at (239,180); pix_en held low for 5 clk mid-line -> all outputs frozen, then resume without lost or duplicated addresses.
